// File: rtl/mini_mips_pkg.sv
// Shared register-file constants and the writeback entry type for the mini MIPS core.
package mini_mips_pkg;
  localparam int REG_COUNT  = 32;
  localparam int WORD_WIDTH = 32;
  localparam int REG_ADDR_W = $clog2(REG_COUNT);

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [WORD_WIDTH-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Pending-writeback FIFO: head visible combinationally, push/pop take effect at posedge.
// Backpressure: in_rdy low while full or in reset; a same-cycle pop does not free a slot for a push.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic [W-1:0]           in_dat,
  input  logic                   pop,
  output logic                   empty,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          push;
  logic          do_pop;

  assign in_rdy = !rst && (count < FULL);
  assign empty  = (count == '0);
  assign head   = mem[rd_ptr];
  assign push   = in_vld && in_rdy;
  assign do_pop = pop && !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/regfile_writeback_unit.sv
// Register-file write port: ALU beats queued load results, winner committed 1 cycle later; busy scoreboard + bypass.
// Backpressure only on the mem path (mem_ready); optional starvation guard under WB_FIFO_STARVE_GUARD_EN.
module regfile_writeback_unit
  import mini_mips_pkg::*;
#(
  parameter  int COUNT      = REG_COUNT,
  parameter  int BUS_WIDTH  = WORD_WIDTH,
  parameter  int FIFO_DEPTH = 4,
  localparam int ADDR_WIDTH = $clog2(COUNT),
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_addr,
  input  logic [BUS_WIDTH-1:0]  alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [BUS_WIDTH-1:0]  mem_data,
  input  logic                  rsv_en,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [BUS_WIDTH-1:0]  data_in,
  input  logic [ADDR_WIDTH-1:0] query_addr1,
  input  logic [ADDR_WIDTH-1:0] query_addr2,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  fwd_valid1,
  output logic [BUS_WIDTH-1:0]  fwd_data1,
  output logic                  fwd_valid2,
  output logic [BUS_WIDTH-1:0]  fwd_data2,
  output logic [CW-1:0]         fifo_count
);
  localparam int EW = ADDR_WIDTH + BUS_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZADDR = ADDR_WIDTH'(ZERO_REG);

  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [EW-1:0]         fifo_head;
  logic                  alu_live;
  logic                  win_vld;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [BUS_WIDTH-1:0]  win_data;
  logic [COUNT-1:0]      busy;

  // Writes to $zero are accepted on the handshake but never stored.
  wb_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .in_vld (mem_valid && (mem_addr != ZADDR)),
    .in_rdy (mem_ready),
    .in_dat ({mem_addr, mem_data}),
    .pop    (fifo_pop),
    .empty  (fifo_empty),
    .head   (fifo_head),
    .count  (fifo_count)
  );

  assign alu_live = alu_valid && (alu_addr != ZADDR);

`ifdef WB_FIFO_STARVE_GUARD_EN
  logic [2:0]            starve_cnt;
  logic                  skid_vld;
  logic                  skid_load;
  logic [ADDR_WIDTH-1:0] skid_addr;
  logic [BUS_WIDTH-1:0]  skid_data;

  // Priority: parked ALU result, then a forced FIFO head, then the live ALU.
  always_comb begin
    win_vld   = 1'b0;
    win_addr  = alu_addr;
    win_data  = alu_data;
    fifo_pop  = 1'b0;
    skid_load = 1'b0;
    if (skid_vld) begin
      win_vld   = 1'b1;
      win_addr  = skid_addr;
      win_data  = skid_data;
      skid_load = alu_live;
    end else if (!fifo_empty && (!alu_live || starve_cnt == 3'd7)) begin
      win_vld               = 1'b1;
      {win_addr, win_data}  = fifo_head;
      fifo_pop              = 1'b1;
      skid_load             = alu_live;
    end else if (alu_live) begin
      win_vld = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_addr <= alu_addr;
      skid_data <= alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      skid_vld   <= 1'b0;
    end else begin
      skid_vld <= skid_load;
      if (fifo_pop)
        starve_cnt <= '0;
      else if (!fifo_empty && win_vld && starve_cnt != 3'd7)
        starve_cnt <= starve_cnt + 3'd1;
    end
  end
`else
  always_comb begin
    win_vld  = alu_live || !fifo_empty;
    fifo_pop = !alu_live && !fifo_empty;
    if (alu_live) {win_addr, win_data} = {alu_addr, alu_data};
    else          {win_addr, win_data} = fifo_head;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en      <= 1'b0;
      write_addr <= '0;
      data_in    <= '0;
    end else begin
      wr_en <= win_vld;
      if (win_vld) begin
        write_addr <= win_addr;
        data_in    <= win_data;
      end
    end
  end

  // A new reservation outranks the commit retiring the previous producer.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int i = 1; i < COUNT; i++) begin
        if (rsv_en && rsv_addr == ADDR_WIDTH'(i))
          busy[i] <= 1'b1;
        else if (wr_en && write_addr == ADDR_WIDTH'(i))
          busy[i] <= 1'b0;
      end
    end
  end

  assign busy1 = !rst && (query_addr1 != ZADDR) && busy[query_addr1];
  assign busy2 = !rst && (query_addr2 != ZADDR) && busy[query_addr2];

  assign fwd_valid1 = !rst && wr_en && (query_addr1 == write_addr) && (query_addr1 != ZADDR);
  assign fwd_valid2 = !rst && wr_en && (query_addr2 == write_addr) && (query_addr2 != ZADDR);
  assign fwd_data1  = fwd_valid1 ? data_in : '0;
  assign fwd_data2  = fwd_valid2 ? data_in : '0;
endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Directed + random bench for regfile_writeback_unit against a queue-based reference model.
module tb_regfile_writeback_unit;
  import mini_mips_pkg::*;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          rsv_en;
  logic [AW-1:0] rsv_addr;
  logic          wr_en;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] data_in;
  logic [AW-1:0] query_addr1;
  logic [AW-1:0] query_addr2;
  logic          busy1;
  logic          busy2;
  logic          fwd_valid1;
  logic [DW-1:0] fwd_data1;
  logic          fwd_valid2;
  logic [DW-1:0] fwd_data2;
  logic [2:0]    fifo_count;

  always #5 clk = ~clk;

  regfile_writeback_unit #(.COUNT(32), .BUS_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .wr_en(wr_en), .write_addr(write_addr), .data_in(data_in),
    .query_addr1(query_addr1), .query_addr2(query_addr2),
    .busy1(busy1), .busy2(busy2),
    .fwd_valid1(fwd_valid1), .fwd_data1(fwd_data1),
    .fwd_valid2(fwd_valid2), .fwd_data2(fwd_data2),
    .fifo_count(fifo_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the committed write, the pending queue, and one busy flag per register.
  logic          m_wr_en;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  wb_entry_t     m_q[$];
  bit            m_busy[32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task model_edge();
    bit        rdy;
    wb_entry_t e;
    if (rst) begin
      m_wr_en = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
      m_q.delete();
      foreach (m_busy[i]) m_busy[i] = 1'b0;
    end else begin
      rdy = (m_q.size() < DEPTH);
      if (m_wr_en) m_busy[m_waddr] = 1'b0;
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
      if (alu_valid && alu_addr != 0) begin
        m_wr_en = 1'b1; m_waddr = alu_addr; m_wdata = alu_data;
      end else if (m_q.size() > 0) begin
        e = m_q.pop_front();
        m_wr_en = 1'b1; m_waddr = e.addr; m_wdata = e.data;
      end else begin
        m_wr_en = 1'b0;
      end
      if (mem_valid && rdy && mem_addr != 0) m_q.push_back('{addr: mem_addr, data: mem_data});
    end
  endtask

  task check_all();
    logic eb1, eb2, ef1, ef2;
    eb1 = !rst && query_addr1 != 0 && m_busy[query_addr1];
    eb2 = !rst && query_addr2 != 0 && m_busy[query_addr2];
    ef1 = !rst && m_wr_en && query_addr1 == m_waddr && query_addr1 != 0;
    ef2 = !rst && m_wr_en && query_addr2 == m_waddr && query_addr2 != 0;
    chk("wr_en",      64'(wr_en),      64'(m_wr_en));
    chk("write_addr", 64'(write_addr), 64'(m_waddr));
    chk("data_in",    64'(data_in),    64'(m_wdata));
    chk("fifo_count", 64'(fifo_count), 64'(m_q.size()));
    chk("mem_ready",  64'(mem_ready),  64'(!rst && m_q.size() < DEPTH));
    chk("busy1",      64'(busy1),      64'(eb1));
    chk("busy2",      64'(busy2),      64'(eb2));
    chk("fwd_valid1", 64'(fwd_valid1), 64'(ef1));
    chk("fwd_valid2", 64'(fwd_valid2), 64'(ef2));
    chk("fwd_data1",  64'(fwd_data1),  64'(ef1 ? m_wdata : 32'h0));
    chk("fwd_data2",  64'(fwd_data2),  64'(ef2 ? m_wdata : 32'h0));
  endtask

  task step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task idle();
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    query_addr1 = '0;
    query_addr2 = '0;

    // Reset then idle
    step();
    step();
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_mem_ready", 64'(mem_ready), 64'(0));
    chk("rst_count", 64'(fifo_count), 64'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_mem_ready", 64'(mem_ready), 64'(1));
    step();

    // ALU latency and bypass
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    idle();
    query_addr1 = 5'd5;
    #1;
    chk("lat_wr_en", 64'(wr_en), 64'(1));
    chk("lat_addr", 64'(write_addr), 64'(5));
    chk("lat_data", 64'(data_in), 64'hDEADBEEF);
    chk("lat_fwd_valid1", 64'(fwd_valid1), 64'(1));
    chk("lat_fwd_data1", 64'(fwd_data1), 64'hDEADBEEF);
    step();
    chk("lat_idle_wr_en", 64'(wr_en), 64'(0));

    // FIFO fill under ALU pressure, then drain in order
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h33;
    mem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_addr = 5'(8 + i);
      mem_data = 32'h100 + 32'(i);
      step();
    end
    chk("full_count", 64'(fifo_count), 64'(4));
    chk("full_ready", 64'(mem_ready), 64'(0));
    alu_valid = 1'b0;
    mem_addr = 5'd13; mem_data = 32'h1313;
    step();
    chk("full_pop_no_push", 64'(fifo_count), 64'(3));
    chk("drain0", 64'(write_addr), 64'(8));
    mem_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      step();
      chk("drain_wr_en", 64'(wr_en), 64'(1));
      chk("drain_addr", 64'(write_addr), 64'(8 + i));
      chk("drain_data", 64'(data_in), 64'(32'h100 + 32'(i)));
    end
    step();
    chk("drain_done", 64'(wr_en), 64'(0));

    // Zero register handling
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h44;
    mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h77;
    step();
    mem_valid = 1'b0; alu_addr = 5'd0;
    step();
    chk("zero_alu_wr_en", 64'(wr_en), 64'(1));
    chk("zero_alu_addr", 64'(write_addr), 64'(7));
    chk("zero_alu_data", 64'(data_in), 64'h77);
    alu_addr = 5'd3;
    mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'hBAD;
    step();
    chk("zero_mem_count", 64'(fifo_count), 64'(0));
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd0;
    step();
    rsv_en = 1'b0;
    step();

    // Scoreboard race: reservation coincides with commit
    rsv_en = 1'b1; rsv_addr = 5'd12; query_addr1 = 5'd12;
    step();
    rsv_en = 1'b0;
    chk("sb_set", 64'(busy1), 64'(1));
    alu_valid = 1'b1; alu_addr = 5'd12; alu_data = 32'hC;
    step();
    alu_valid = 1'b0;
    rsv_en = 1'b1; rsv_addr = 5'd12;
    step();
    chk("sb_race_busy", 64'(busy1), 64'(1));
    rsv_en = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd12; alu_data = 32'hD;
    step();
    alu_valid = 1'b0;
    step();
    chk("sb_clear", 64'(busy1), 64'(0));

    // Reset mid-operation
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h55;
    mem_valid = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd25; query_addr2 = 5'd25;
    for (int i = 0; i < 3; i++) begin
      mem_addr = 5'(20 + i);
      mem_data = 32'h200 + 32'(i);
      step();
    end
    chk("pre_rst_count", 64'(fifo_count), 64'(3));
    chk("pre_rst_busy2", 64'(busy2), 64'(1));
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_rst_wr_en", 64'(wr_en), 64'(0));
      chk("mid_rst_count", 64'(fifo_count), 64'(0));
      chk("mid_rst_busy2", 64'(busy2), 64'(0));
    end

    // Random traffic on a narrow address range to provoke collisions
    for (int c = 0; c < 400; c++) begin
      rst         = ($urandom_range(0, 63) == 0);
      alu_valid   = 1'($urandom_range(0, 1));
      alu_addr    = 5'($urandom_range(0, 7));
      alu_data    = $urandom;
      mem_valid   = 1'($urandom_range(0, 1));
      mem_addr    = 5'($urandom_range(0, 7));
      mem_data    = $urandom;
      rsv_en      = 1'($urandom_range(0, 1));
      rsv_addr    = 5'($urandom_range(0, 7));
      query_addr1 = 5'($urandom_range(0, 7));
      query_addr2 = 5'($urandom_range(0, 7));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_writeback_unit.md
Name: regfile_writeback_unit

Overview:
- Writer/initiator side of the register file's write port. Arbitrates register writebacks from the single-cycle ALU path and the variable-latency load/multi-cycle path, and drives write_addr/data_in/wr_en.
- Keeps a busy scoreboard so issue logic can detect RAW hazards.
- The register file is read-first on same-cycle read/write, so this block also supplies bypass data for the write being committed that cycle.

Parameters:
- COUNT, 32, number of architectural registers; register 0 is $zero.
- BUS_WIDTH, 32, data width.
- FIFO_DEPTH, 4, pending load/multi-cycle writebacks held; power of two, at least 2.
- ADDR_WIDTH, $clog2(COUNT), localparam.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result available this cycle; no backpressure.
- alu_addr  in  ADDR_WIDTH  ALU destination register.
- alu_data  in  BUS_WIDTH  ALU result.
- mem_valid  in  1  load/multi-cycle result offered.
- mem_ready  out  1  FIFO can accept an entry.
- mem_addr  in  ADDR_WIDTH  load/multi-cycle destination register.
- mem_data  in  BUS_WIDTH  load/multi-cycle result.
- rsv_en  in  1  issue reserves a destination register.
- rsv_addr  in  ADDR_WIDTH  register being reserved.
- wr_en  out  1  register file write enable.
- write_addr  out  ADDR_WIDTH  register file write address.
- data_in  out  BUS_WIDTH  register file write data.
- query_addr1  in  ADDR_WIDTH  decode read address 1.
- query_addr2  in  ADDR_WIDTH  decode read address 2.
- busy1  out  1  query_addr1 has an outstanding producer.
- busy2  out  1  query_addr2 has an outstanding producer.
- fwd_valid1  out  1  fwd_data1 overrides register file data_out1.
- fwd_data1  out  BUS_WIDTH  bypass data for query_addr1.
- fwd_valid2  out  1  fwd_data2 overrides register file data_out2.
- fwd_data2  out  BUS_WIDTH  bypass data for query_addr2.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst high at posedge): wr_en=0, write_addr=0, data_in=0, FIFO empty, fifo_count=0, scoreboard cleared. Reset mid-operation discards queued entries.
- While rst is high: mem_ready=0, all busy and fwd_valid outputs 0.
- Enqueue: mem_ready = !rst && fifo_count < FIFO_DEPTH. The entry is accepted when mem_valid && mem_ready.
  - Addressed to 0: accepted and discarded, not stored.
  - When full, no enqueue even if a dequeue occurs the same cycle.
- Arbitration, once per cycle:
  - An ALU request is a live request if alu_valid is high and alu_addr is nonzero. A live ALU request always wins.
  - Otherwise, if the FIFO is non-empty, the head is dequeued.
  - An ALU request to address 0 is dropped and does not block the FIFO.
- Commit stage: the winner is registered onto wr_en/write_addr/data_in, giving latency 1.
  - Request at cycle N → wr_en high during cycle N+1 → register file updated at the end of N+1.
  - wr_en=0 in cycles with no winner. write_addr and data_in hold their last value.
- FIFO wraps in pointer arithmetic; fifo_count is exact from 0 to FIFO_DEPTH.
- Ordering:
  - FIFO entries are written in arrival order.
  - ALU and FIFO entries to the same register are not reordered or checked; the scoreboard and issue logic prevent this case.
- Scoreboard: one busy bit per register 1..COUNT-1.
  - Set at posedge when rsv_en is high and rsv_addr is nonzero.
  - Cleared at the posedge where wr_en=1 for that write_addr.
  - Set and clear on the same address in the same cycle: set wins.
  - busyN = busy[query_addrN]; forced to 0 when the address is 0. Combinational.
- Bypass: when wr_en=1, query_addrN==write_addr and query_addrN!=0, then fwd_validN=1 and fwd_dataN=data_in. Otherwise fwd_validN=0 and fwd_dataN=0. Combinational.

Optional Feature:
- Macro: WB_FIFO_STARVE_GUARD_EN.
- Defined: a 3-bit counter counts consecutive cycles in which the FIFO is non-empty but loses to the ALU.
  - At 7, the FIFO head wins the next cycle, and the ALU request that cycle is registered into a one-entry skid register. The skid has priority over both sources in the following cycle.
  - The counter resets on any FIFO dequeue and on rst.
- Undefined: strict ALU priority; a stream of ALU writes may starve the FIFO indefinitely.

Decomposition:
- Package mini_mips_pkg holds:
  - REG_COUNT=32 and WORD_WIDTH=32.
  - typedef wb_entry_t {addr, data}.
  - ZERO_REG=0.
- Sub-module wb_fifo (parameters DEPTH and entry width; valid/ready in, pop/empty/head out, count).
- Arbiter, commit stage, scoreboard and bypass logic stay in the top module.

Test Plan:
- Reset then idle: rst high for 2 cycles → wr_en=0, fifo_count=0, busy1=busy2=0, mem_ready=0 during reset and 1 on the first cycle after.
- ALU latency: alu_valid=1, alu_addr=5, alu_data=0xDEADBEEF at cycle N → cycle N+1 shows wr_en=1, write_addr=5, data_in=0xDEADBEEF. With query_addr1=5 in N+1, fwd_valid1=1 and fwd_data1=0xDEADBEEF.
- FIFO fill/back-pressure: 4 mem writes to regs 8..11 while alu_valid=1 to reg 3 → mem_ready=0 at fifo_count=4. After ALU idles, writes commit in order 8, 9, 10, 11 on consecutive cycles.
- Zero register:
  - alu_addr=0 with FIFO holding reg 7 → reg 7 commits next cycle.
  - mem write to 0 → fifo_count unchanged.
  - rsv_addr=0 → busy never set.
- Scoreboard race: reg 12 reserved; in the cycle its write has wr_en=1, rsv_en=1 for reg 12 again → busy stays 1. Next commit to reg 12 with no new reservation → busy cleared.
- Reset mid-operation: FIFO holds 3 entries and rst pulses one cycle → fifo_count=0, no further wr_en, scoreboard cleared.
